// File: rtl/writeback_unit_pkg.sv
// Shared widths and grant encoding for the writeback unit and its scoreboard.
package writeback_unit_pkg;

   localparam int XLEN       = 32;
   localparam int REG_ADDR_W = 5;
   localparam int NUM_REGS   = 32;

   // Identity of the source granted most recently by the arbiter.
   typedef enum logic {
      GNT_ALU = 1'b0,
      GNT_LD  = 1'b1
   } grant_e;

endpackage

// File: rtl/writeback_unit_wb_scoreboard.sv
// Outstanding-load scoreboard: one pending bit per architectural register,
// set on load issue, cleared on load return, and queried by decode for hazards.
module wb_scoreboard
   import writeback_unit_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  set_en,
   input  logic [REG_ADDR_W-1:0] set_idx,
   input  logic                  clr_en,
   input  logic [REG_ADDR_W-1:0] clr_idx,
   input  logic [REG_ADDR_W-1:0] rs1_addr,
   input  logic [REG_ADDR_W-1:0] rs2_addr,
   input  logic                  wb_we,
   input  logic [REG_ADDR_W-1:0] wb_addr,
   output logic                  rs1_busy,
   output logic                  rs2_busy
);

   logic [NUM_REGS-1:0] pending_q;
   logic [NUM_REGS-1:0] pending_d;

   // Next pending vector: clear first so a same-cycle issue to the same
   // register wins (a newer load is now outstanding). x0 is never pending.
   always_comb begin
      pending_d = pending_q;
      if (clr_en) begin
         pending_d[clr_idx] = 1'b0;
      end
      if (set_en && (set_idx != '0)) begin
         pending_d[set_idx] = 1'b1;
      end
      pending_d[0] = 1'b0;
   end

   // Pending vector register.
   always_ff @(posedge clk) begin
      if (rst) begin
         pending_q <= '0;
      end else begin
         pending_q <= pending_d;
      end
   end

   // Busy while the load is outstanding, and also during the cycle its data
   // is on the register-file write port (not yet readable from the file).
   always_comb begin
      rs1_busy = (rs1_addr != '0) &&
                 (pending_q[rs1_addr] || (wb_we && (wb_addr == rs1_addr)));
      rs2_busy = (rs2_addr != '0) &&
                 (pending_q[rs2_addr] || (wb_we && (wb_addr == rs2_addr)));
   end

endmodule

// File: rtl/writeback_unit.sv
// Writeback unit: round-robin arbitration between the ALU and load-return
// sources, a registered register-file write port, and load hazard tracking.
module writeback_unit
   import writeback_unit_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  alu_valid,
   input  logic [REG_ADDR_W-1:0] alu_rd_addr,
   input  logic [XLEN-1:0]       alu_rd_data,
   output logic                  alu_ready,
   input  logic                  ld_valid,
   input  logic [REG_ADDR_W-1:0] ld_rd_addr,
   input  logic [XLEN-1:0]       ld_rd_data,
   output logic                  ld_ready,
   input  logic                  issue_valid,
   input  logic [REG_ADDR_W-1:0] issue_rd,
   input  logic [REG_ADDR_W-1:0] rs1_addr,
   input  logic [REG_ADDR_W-1:0] rs2_addr,
   output logic                  rs1_busy,
   output logic                  rs2_busy,
   output logic [REG_ADDR_W-1:0] rd_addr,
   output logic [XLEN-1:0]       rd_data,
   output logic                  rd_we
);

   grant_e                last_grant_q, last_grant_d;
   logic [REG_ADDR_W-1:0] rd_addr_q, rd_addr_d;
   logic [XLEN-1:0]       rd_data_q, rd_data_d;
   logic                  rd_we_q, rd_we_d;
   logic                  alu_fire, ld_fire;

   // Grant: a lone requester always wins; on conflict the source that was
   // not granted most recently wins.
   always_comb begin
      alu_ready = alu_valid && !(ld_valid && (last_grant_q == GNT_ALU));
      ld_ready  = ld_valid  && !(alu_valid && (last_grant_q == GNT_LD));
      alu_fire  = alu_valid && alu_ready;
      ld_fire   = ld_valid && ld_ready;
   end

   // Next write-port contents and arbitration history from the accepted transfer.
   always_comb begin
      rd_addr_d    = rd_addr_q;
      rd_data_d    = rd_data_q;
      rd_we_d      = 1'b0;
      last_grant_d = last_grant_q;
      if (alu_fire) begin
         rd_addr_d    = alu_rd_addr;
         rd_data_d    = alu_rd_data;
         rd_we_d      = (alu_rd_addr != '0);
         last_grant_d = GNT_ALU;
      end else if (ld_fire) begin
         rd_addr_d    = ld_rd_addr;
         rd_data_d    = ld_rd_data;
         rd_we_d      = (ld_rd_addr != '0);
         last_grant_d = GNT_LD;
      end
   end

   // Output and arbitration registers; reset leaves ALU as last grant so the
   // load source wins the first conflict.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_addr_q    <= '0;
         rd_data_q    <= '0;
         rd_we_q      <= 1'b0;
         last_grant_q <= GNT_ALU;
      end else begin
         rd_addr_q    <= rd_addr_d;
         rd_data_q    <= rd_data_d;
         rd_we_q      <= rd_we_d;
         last_grant_q <= last_grant_d;
      end
   end

   assign rd_addr = rd_addr_q;
   assign rd_data = rd_data_q;
   assign rd_we   = rd_we_q;

   wb_scoreboard u_scoreboard (
      .clk      (clk),
      .rst      (rst),
      .set_en   (issue_valid),
      .set_idx  (issue_rd),
      .clr_en   (ld_fire),
      .clr_idx  (ld_rd_addr),
      .rs1_addr (rs1_addr),
      .rs2_addr (rs2_addr),
      .wb_we    (rd_we_q),
      .wb_addr  (rd_addr_q),
      .rs1_busy (rs1_busy),
      .rs2_busy (rs2_busy)
   );

endmodule

// File: tb/tb_writeback_unit.sv
// Testbench for writeback_unit: directed scenarios followed by constrained
// random traffic, all compared against a transaction-level reference model.
module tb_writeback_unit;

   logic        clk;
   logic        rst;
   logic        alu_valid;
   logic [4:0]  alu_rd_addr;
   logic [31:0] alu_rd_data;
   logic        alu_ready;
   logic        ld_valid;
   logic [4:0]  ld_rd_addr;
   logic [31:0] ld_rd_data;
   logic        ld_ready;
   logic        issue_valid;
   logic [4:0]  issue_rd;
   logic [4:0]  rs1_addr;
   logic [4:0]  rs2_addr;
   logic        rs1_busy;
   logic        rs2_busy;
   logic [4:0]  rd_addr;
   logic [31:0] rd_data;
   logic        rd_we;

   int checks   = 0;
   int failures = 0;

   // Reference model state (architectural view).
   bit          m_alu_was_last;   // 1: ALU was the most recently granted source
   bit          m_pend [32];
   bit          m_we;
   logic [4:0]  m_addr;
   logic [31:0] m_data;
   bit          exp_alu_rdy;
   bit          exp_ld_rdy;

   writeback_unit dut (
      .clk         (clk),
      .rst         (rst),
      .alu_valid   (alu_valid),
      .alu_rd_addr (alu_rd_addr),
      .alu_rd_data (alu_rd_data),
      .alu_ready   (alu_ready),
      .ld_valid    (ld_valid),
      .ld_rd_addr  (ld_rd_addr),
      .ld_rd_data  (ld_rd_data),
      .ld_ready    (ld_ready),
      .issue_valid (issue_valid),
      .issue_rd    (issue_rd),
      .rs1_addr    (rs1_addr),
      .rs2_addr    (rs2_addr),
      .rs1_busy    (rs1_busy),
      .rs2_busy    (rs2_busy),
      .rd_addr     (rd_addr),
      .rd_data     (rd_data),
      .rd_we       (rd_we)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic bit model_busy(input logic [4:0] r);
      if (r == 5'd0) return 1'b0;
      return m_pend[r] || (m_we && (m_addr == r));
   endfunction

   task automatic model_reset();
      m_alu_was_last = 1'b1;
      m_we   = 1'b0;
      m_addr = '0;
      m_data = '0;
      for (int i = 0; i < 32; i++) m_pend[i] = 1'b0;
   endtask

   task automatic idle_inputs();
      alu_valid   = 1'b0;
      alu_rd_addr = '0;
      alu_rd_data = '0;
      ld_valid    = 1'b0;
      ld_rd_addr  = '0;
      ld_rd_data  = '0;
      issue_valid = 1'b0;
      issue_rd    = '0;
   endtask

   // One clock cycle: inputs are already applied by the caller (at posedge+1).
   // Checks combinational outputs before the edge and registered outputs after.
   task automatic run_cycle(input string tag);
      #1;
      if (alu_valid && ld_valid) begin
         exp_alu_rdy = !m_alu_was_last;
         exp_ld_rdy  = m_alu_was_last;
      end else begin
         exp_alu_rdy = alu_valid;
         exp_ld_rdy  = ld_valid;
      end
      if (!rst) begin
         check({tag, ".alu_ready"}, {31'd0, alu_ready}, {31'd0, exp_alu_rdy});
         check({tag, ".ld_ready"},  {31'd0, ld_ready},  {31'd0, exp_ld_rdy});
      end
      check({tag, ".rs1_busy"}, {31'd0, rs1_busy}, {31'd0, model_busy(rs1_addr)});
      check({tag, ".rs2_busy"}, {31'd0, rs2_busy}, {31'd0, model_busy(rs2_addr)});
      @(posedge clk);
      if (rst) begin
         model_reset();
      end else begin
         if (exp_alu_rdy) begin
            m_we = (alu_rd_addr != 0); m_addr = alu_rd_addr; m_data = alu_rd_data;
            m_alu_was_last = 1'b1;
         end else if (exp_ld_rdy) begin
            m_we = (ld_rd_addr != 0); m_addr = ld_rd_addr; m_data = ld_rd_data;
            m_alu_was_last = 1'b0;
         end else begin
            m_we = 1'b0;
         end
         if (exp_ld_rdy) m_pend[ld_rd_addr] = 1'b0;
         if (issue_valid && issue_rd != 0) m_pend[issue_rd] = 1'b1;
         m_pend[0] = 1'b0;
      end
      #1;
      check({tag, ".rd_we"},   {31'd0, rd_we},   {31'd0, m_we});
      check({tag, ".rd_addr"}, {27'd0, rd_addr}, {27'd0, m_addr});
      check({tag, ".rd_data"}, rd_data,          m_data);
      $display("txn %s alu_v=%0b ld_v=%0b gnt_alu=%0b gnt_ld=%0b we=%0b addr=%0d data=%h",
               tag, alu_valid, ld_valid, exp_alu_rdy, exp_ld_rdy, rd_we, rd_addr, rd_data);
   endtask

   initial begin
      bit alu_hold;
      bit ld_hold;
      model_reset();
      idle_inputs();
      rs1_addr = '0;
      rs2_addr = '0;
      rst      = 1'b1;
      @(posedge clk); #1;
      run_cycle("reset");
      check("reset.rd_we_const", {31'd0, rd_we}, 32'd0);
      rst = 1'b0;

      // Single ALU write, then idle.
      alu_valid = 1'b1; alu_rd_addr = 5'd5; alu_rd_data = 32'hDEADBEEF;
      run_cycle("alu_single");
      check("alu_single.data_const", rd_data, 32'hDEADBEEF);
      idle_inputs();
      run_cycle("alu_idle");

      // Conflict round-robin after a reset: LD, ALU, LD, ALU.
      rst = 1'b1; run_cycle("rr_reset"); rst = 1'b0;
      alu_valid = 1'b1; alu_rd_addr = 5'd1; alu_rd_data = 32'hAAAA0001;
      ld_valid  = 1'b1; ld_rd_addr  = 5'd2; ld_rd_data  = 32'hBBBB0002;
      for (int i = 0; i < 4; i++) run_cycle($sformatf("rr%0d", i));
      idle_inputs();
      run_cycle("rr_idle");

      // Load hazard lifetime on x7.
      issue_valid = 1'b1; issue_rd = 5'd7; rs1_addr = 5'd7;
      run_cycle("haz_issue");
      idle_inputs();
      run_cycle("haz_wait");
      ld_valid = 1'b1; ld_rd_addr = 5'd7; ld_rd_data = 32'h00001234;
      run_cycle("haz_return");
      idle_inputs();
      run_cycle("haz_wb");
      run_cycle("haz_clear");
      check("haz_clear.busy_const", {31'd0, rs1_busy}, 32'd0);

      // Same-cycle issue and return on x9: set wins.
      issue_valid = 1'b1; issue_rd = 5'd9; rs2_addr = 5'd9;
      ld_valid = 1'b1; ld_rd_addr = 5'd9; ld_rd_data = 32'h99;
      run_cycle("setclr");
      idle_inputs();
      run_cycle("setclr_wb");
      run_cycle("setclr_after");
      check("setclr_after.busy_const", {31'd0, rs2_busy}, 32'd1);

      // x0 writes and issues.
      alu_valid = 1'b1; alu_rd_addr = 5'd0; alu_rd_data = 32'hFFFFFFFF;
      run_cycle("x0_alu");
      check("x0_alu.we_const", {31'd0, rd_we}, 32'd0);
      idle_inputs();
      issue_valid = 1'b1; issue_rd = 5'd0; rs1_addr = 5'd0;
      run_cycle("x0_issue");
      idle_inputs();
      run_cycle("x0_query");

      // Reset with a pending load and a transfer in flight.
      issue_valid = 1'b1; issue_rd = 5'd3;
      run_cycle("mid_issue");
      idle_inputs();
      alu_valid = 1'b1; alu_rd_addr = 5'd4; alu_rd_data = 32'h44;
      issue_valid = 1'b1; issue_rd = 5'd6;
      rst = 1'b1;
      run_cycle("mid_rst");
      rst = 1'b0;
      idle_inputs();
      rs1_addr = 5'd3; rs2_addr = 5'd9;
      run_cycle("mid_after");
      alu_valid = 1'b1; alu_rd_addr = 5'd1; alu_rd_data = 32'h11;
      ld_valid  = 1'b1; ld_rd_addr  = 5'd2; ld_rd_data  = 32'h22;
      run_cycle("mid_conflict");
      check("mid_conflict.ld_wins", {27'd0, rd_addr}, 32'd2);
      idle_inputs();

      // Random traffic; a source that was not granted keeps its request stable.
      alu_hold = 1'b0;
      ld_hold  = 1'b0;
      for (int n = 0; n < 400; n++) begin
         rst = ($urandom_range(0, 49) == 0);
         if (!alu_hold) begin
            alu_valid   = $urandom_range(0, 1);
            alu_rd_addr = 5'($urandom_range(0, 7));
            alu_rd_data = $urandom;
         end
         if (!ld_hold) begin
            ld_valid   = $urandom_range(0, 1);
            ld_rd_addr = 5'($urandom_range(0, 7));
            ld_rd_data = $urandom;
         end
         issue_valid = ($urandom_range(0, 3) == 0);
         issue_rd    = 5'($urandom_range(0, 7));
         rs1_addr    = 5'($urandom_range(0, 7));
         rs2_addr    = 5'($urandom_range(0, 7));
         run_cycle($sformatf("rnd%0d", n));
         alu_hold = alu_valid && !exp_alu_rdy && !rst;
         ld_hold  = ld_valid && !exp_ld_rdy && !rst;
      end
      rst = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Watchdog so the run always terminates.
   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/writeback_unit.md
WRITEBACK_UNIT -- requirements
Module: writeback_unit

Interface
REQ-001 The block SHALL have exactly one clock and one reset: the reset is synchronous and active-high.
REQ-002 Port clk, input, 1 bit: sole clock; all state updates on its rising edge.
REQ-003 Port rst, input, 1 bit: synchronous active-high reset, sampled on the rising edge of clk.
REQ-004 Ports alu_valid (in, 1), alu_rd_addr (in, 5), alu_rd_data (in, 32), alu_ready (out, 1): single-cycle ALU result source, valid/ready handshake.
REQ-005 Ports ld_valid (in, 1), ld_rd_addr (in, 5), ld_rd_data (in, 32), ld_ready (out, 1): load-return result source, valid/ready handshake.
REQ-006 Ports issue_valid (in, 1), issue_rd (in, 5): a load was issued that will later write issue_rd.
REQ-007 Ports rs1_addr (in, 5), rs2_addr (in, 5), rs1_busy (out, 1), rs2_busy (out, 1): operand hazard query for decode.
REQ-008 Ports rd_addr (out, 5), rd_data (out, 32), rd_we (out, 1): register-file write port, driven from flops.

Function
REQ-009 A transfer on a source SHALL occur in a cycle where both valid and ready are high; valid held high without ready SHALL keep addr/data stable (source obligation, asserted in bench).
REQ-010 Ready SHALL be combinational grant: only one source gets ready=1 per cycle; a lone valid source SHALL always be granted.
REQ-011 When both sources are valid, grant SHALL alternate round-robin using a 1-bit last_grant flop, granting the source not granted most recently.
REQ-012 last_grant SHALL update on every accepted transfer to the granted source, and hold otherwise.
REQ-013 An accepted transfer SHALL appear on rd_addr/rd_data the next cycle, with rd_we=1 only if the accepted rd_addr != 0.
REQ-014 Transfers to x0 SHALL be accepted (handshake completes) but produce rd_we=0.
REQ-015 With no accepted transfer, rd_we SHALL be 0 the next cycle; rd_addr/rd_data hold their last values.
REQ-016 Scoreboard: 32-bit pending vector; issue_valid with issue_rd != 0 SHALL set pending[issue_rd] at the clock edge.
REQ-017 An accepted load-source transfer SHALL clear pending[ld_rd_addr]; ALU transfers SHALL NOT touch pending.
REQ-018 Simultaneous set and clear of the same index in one cycle: set SHALL win (newer load outstanding).
REQ-019 pending[0] SHALL always read 0.
REQ-020 rsN_busy SHALL be combinational: pending[rsN_addr] OR (rd_we AND rd_addr == rsN_addr), forced 0 when rsN_addr == 0.
REQ-021 Repeated issue to an already-pending register SHALL leave it pending (no count; single outstanding load per register by contract).

Reset
REQ-022 On rst: rd_we=0, rd_addr=0, rd_data=0, pending all zero, last_grant=ALU (so the load source wins the first conflict).
REQ-023 Reset SHALL take priority over any simultaneous handshake or issue; ready outputs during the reset cycle are don't-care, and no transfer SHALL take effect.

Structure
REQ-024 Shared package SHALL hold: XLEN=32, REG_ADDR_W=5, NUM_REGS=32, grant encoding constants (GNT_ALU, GNT_LD).
REQ-025 One sub-module is natural: wb_scoreboard (pending vector, set/clear, busy lookup); arbiter and output flops stay in writeback_unit.

Verification
REQ-026 Reset, then alu_valid=1, rd=5, data=0xDEADBEEF -> alu_ready=1; next cycle rd_we=1, rd_addr=5, rd_data=0xDEADBEEF; following cycle rd_we=0.
REQ-027 Both valid for 4 cycles (alu rd=1, ld rd=2) after reset -> grants LD, ALU, LD, ALU; each loser's data held stable until granted.
REQ-028 issue_valid rd=7; query rs1=7 -> rs1_busy=1; ld returns rd=7 data=0x1234 -> busy stays 1 in the rd_we cycle, 0 the cycle after.
REQ-029 ld return rd=9 in the same cycle as issue rd=9 -> pending[9] remains set; rs2=9 busy=1 afterward.
REQ-030 alu rd=0 data=0xFFFFFFFF -> alu_ready=1, next cycle rd_we=0; issue rd=0 -> rs1=0 busy=0.
REQ-031 Assert rst mid-stream with pending[3] set and transfer in flight -> next cycle rd_we=0, all busy=0, next conflict grants LD.
